fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_fetch_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer that chooses the PC source and load enable.
// It holds the PC after reset, squashes the front end after a redirect, and parks
// fetch on a halt request until resume.
// Optional feature: define FETCH_CTRL_PERF_EN to build the redirect and stall
// performance counters. Without it those ports are driven with constant zero.
module fetch_ctrl #(
  parameter int WIDTH       = 32,
  parameter int BOOT_CYCLES = 2,
  parameter int FLUSH_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             branch_taken_step_4,
  input  logic             jump_step_4,
  input  logic             halt_req,
  input  logic             resume,
  output logic             is_load_PC,
  output logic [1:0]       control_mux_for_PC,
  output logic             flush,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] redirect_cnt,
  output logic [WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] boot_cnt_q, boot_cnt_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic       flush_q, flush_d;

  // State register, boot/flush down-counters and registered flush flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BOOT;
      boot_cnt_q  <= 4'(BOOT_CYCLES);
      flush_cnt_q <= 3'd0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      flush_q     <= flush_d;
    end
  end

  // Next-state and fetch controls. In RUN the order is redirect, halt, stall, sequential.
  always_comb begin
    state_d            = state_q;
    boot_cnt_d         = boot_cnt_q;
    flush_cnt_d        = flush_cnt_q;
    is_load_PC         = 1'b0;
    control_mux_for_PC = 2'd0;
    fetch_valid        = 1'b0;
    case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q - 4'd1;
        if (boot_cnt_q <= 4'd1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (branch_taken_step_4 || jump_step_4) begin
          is_load_PC         = 1'b1;
          control_mux_for_PC = jump_step_4 ? 2'd2 : 2'd1;
          flush_cnt_d        = 3'(FLUSH_DEPTH);
          state_d            = FLUSH;
        end else if (halt_req) begin
          state_d = HALT;
        end else if (!stall_req) begin
          is_load_PC  = 1'b1;
          fetch_valid = 1'b1;
        end
      end
      FLUSH: begin
        is_load_PC  = !stall_req;
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_q <= 3'd1) begin
          state_d = RUN;
        end
      end
      HALT: begin
        if (resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // The squash flag is high in exactly the cycles spent in FLUSH, taken from the next state.
  always_comb begin
    flush_d = (state_d == FLUSH);
  end

  assign flush = flush_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [WIDTH-1:0] redirect_cnt_q;
  logic [WIDTH-1:0] stall_cnt_q;
  logic             redirect_hit;
  logic             stall_hit;

  assign redirect_hit = (state_q == RUN) && (branch_taken_step_4 || jump_step_4);
  assign stall_hit    = ((state_q == RUN) || (state_q == FLUSH)) && stall_req && !is_load_PC;

  // Free-running wrap-around counters of accepted redirects and stalled fetch cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (redirect_hit) begin
        redirect_cnt_q <= redirect_cnt_q + WIDTH'(1);
      end
      if (stall_hit) begin
        stall_cnt_q <= stall_cnt_q + WIDTH'(1);
      end
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`else
  assign redirect_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random stimulus for fetch_ctrl, checked against a
// cycle-level behavioural model built from countdowns and a halted flag.
module tb_fetch_ctrl;

  localparam int W     = 32;
  localparam int BOOT  = 2;
  localparam int DEPTH = 3;
`ifdef FETCH_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         stallReq;
  logic         branchTaken;
  logic         jumpReq;
  logic         haltReq;
  logic         resumeReq;
  logic         isLoadPc;
  logic [1:0]   muxSel;
  logic         flushOut;
  logic         fetchValid;
  logic [W-1:0] redirectCnt;
  logic [W-1:0] stallCnt;

  int           vectors;
  int           miscompares;

  int           bootLeft;
  int           flushLeft;
  bit           halted;
  logic [W-1:0] modelRedirects;
  logic [W-1:0] modelStalls;

  fetch_ctrl #(
    .WIDTH       (W),
    .BOOT_CYCLES (BOOT),
    .FLUSH_DEPTH (DEPTH)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_req           (stallReq),
    .branch_taken_step_4 (branchTaken),
    .jump_step_4         (jumpReq),
    .halt_req            (haltReq),
    .resume              (resumeReq),
    .is_load_PC          (isLoadPc),
    .control_mux_for_PC  (muxSel),
    .flush               (flushOut),
    .fetch_valid         (fetchValid),
    .redirect_cnt        (redirectCnt),
    .stall_cnt           (stallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (vector %0d)", tag, obs, exp, vectors);
    end
  endtask

  task automatic modelReset();
    bootLeft       = BOOT;
    flushLeft      = 0;
    halted         = 1'b0;
    modelRedirects = '0;
    modelStalls    = '0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_load"}, 32'(isLoadPc), 32'd0);
    checkOutput({tag, "_mux"}, 32'(muxSel), 32'd0);
    checkOutput({tag, "_flush"}, 32'(flushOut), 32'd0);
    checkOutput({tag, "_valid"}, 32'(fetchValid), 32'd0);
    checkOutput({tag, "_rcnt"}, redirectCnt, 32'd0);
    checkOutput({tag, "_scnt"}, stallCnt, 32'd0);
  endtask

  // Assert reset asynchronously, check the cleared outputs, release one edge later.
  task automatic doReset(input string tag);
    rst = 1'b0;
    stallReq = 1'b0; branchTaken = 1'b0; jumpReq = 1'b0; haltReq = 1'b0; resumeReq = 1'b0;
    #1;
    modelReset();
    checkResetValues(tag);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Drive one cycle of inputs (called just after a rising edge), check at the falling edge.
  task automatic applyStimulus(input string tag, input logic b, input logic j, input logic s,
                               input logic h, input logic r);
    logic       expLoad;
    logic       expValid;
    logic       expFlush;
    logic [1:0] expMux;
    branchTaken = b; jumpReq = j; stallReq = s; haltReq = h; resumeReq = r;
    @(negedge clk);
    checkOutput({tag, "_rcnt"}, redirectCnt, PERF ? modelRedirects : 32'd0);
    checkOutput({tag, "_scnt"}, stallCnt, PERF ? modelStalls : 32'd0);
    expLoad  = 1'b0;
    expValid = 1'b0;
    expMux   = 2'd0;
    expFlush = (flushLeft > 0);
    if (bootLeft > 0) begin
      bootLeft--;
    end else if (flushLeft > 0) begin
      expLoad = !s;
      if (s) modelStalls++;
      flushLeft--;
    end else if (halted) begin
      if (r) halted = 1'b0;
    end else if (b || j) begin
      expLoad = 1'b1;
      expMux  = j ? 2'd2 : 2'd1;
      modelRedirects++;
      flushLeft = DEPTH;
    end else if (h) begin
      halted = 1'b1;
      if (s) modelStalls++;
    end else if (s) begin
      modelStalls++;
    end else begin
      expLoad  = 1'b1;
      expValid = 1'b1;
    end
    checkOutput({tag, "_load"}, 32'(isLoadPc), 32'(expLoad));
    checkOutput({tag, "_mux"}, 32'(muxSel), 32'(expMux));
    checkOutput({tag, "_valid"}, 32'(fetchValid), 32'(expValid));
    checkOutput({tag, "_flush"}, 32'(flushOut), 32'(expFlush));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    stallReq = 1'b0; branchTaken = 1'b0; jumpReq = 1'b0; haltReq = 1'b0; resumeReq = 1'b0;
    modelReset();
    #2;
    doReset("reset");

    $display("[TB] boot sequence");
    applyStimulus("boot1", 0, 0, 0, 0, 0);
    applyStimulus("boot2", 0, 0, 0, 0, 0);
    applyStimulus("run1", 0, 0, 0, 0, 0);
    applyStimulus("run2", 0, 0, 0, 0, 0);

    $display("[TB] branch and jump together, branch ignored during flush");
    applyStimulus("bothredir", 1, 1, 0, 0, 0);
    applyStimulus("flush1", 0, 0, 0, 0, 0);
    applyStimulus("flush2_br", 1, 0, 0, 0, 0);
    applyStimulus("flush3_st", 0, 0, 1, 0, 0);
    applyStimulus("postflush", 0, 0, 0, 0, 0);
    applyStimulus("branchonly", 1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus("flushb", 0, 0, 0, 0, 0);

    $display("[TB] four stall cycles");
    for (int i = 0; i < 4; i++) applyStimulus("stall", 0, 0, 1, 0, 0);
    applyStimulus("afterstall", 0, 0, 0, 0, 0);

    $display("[TB] halt, ignored jump, resume");
    applyStimulus("haltreq", 0, 0, 0, 1, 0);
    applyStimulus("halt_jump", 0, 1, 1, 1, 0);
    applyStimulus("halt_hold", 0, 0, 0, 0, 0);
    applyStimulus("resume", 0, 0, 0, 0, 1);
    applyStimulus("afterres", 0, 0, 0, 0, 0);
    applyStimulus("resumerun", 0, 0, 0, 0, 1);
    applyStimulus("haltlvl", 0, 0, 0, 1, 0);
    applyStimulus("resumelvl", 0, 0, 0, 1, 1);
    applyStimulus("runonce", 0, 0, 0, 1, 0);
    applyStimulus("rehalted", 0, 0, 0, 0, 1);
    applyStimulus("redir_halt", 1, 0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus("flushhalt", 0, 0, 0, 1, 0);
    applyStimulus("halt_after", 0, 0, 0, 0, 0);
    applyStimulus("resume2", 0, 0, 0, 0, 1);

`ifdef FETCH_CTRL_PERF_EN
    $display("[TB] redirect counter wrap");
    force dut.redirect_cnt_q = '1;
    #1;
    release dut.redirect_cnt_q;
    modelRedirects = '1;
    applyStimulus("wrapredir", 0, 1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus("wrapflush", 0, 0, 0, 0, 0);
    applyStimulus("wrapcheck", 0, 0, 0, 0, 0);
`endif

    $display("[TB] reset during flush cycle 2");
    applyStimulus("preredir", 1, 0, 0, 0, 0);
    applyStimulus("midflush1", 0, 0, 0, 0, 0);
    doReset("midflush_rst");
    applyStimulus("reboot1", 0, 0, 0, 0, 0);
    applyStimulus("reboot2", 0, 0, 0, 0, 0);
    applyStimulus("rerun", 0, 0, 0, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    logic'($urandom_range(0, 9) == 0),
                    logic'($urandom_range(0, 11) == 0),
                    logic'($urandom_range(0, 3) == 0),
                    logic'($urandom_range(0, 9) == 0),
                    logic'($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
